pipe_pc_ctrl: RTL and testbench
===============================

PIPE_PC_CTRL -- requirements
Module: pipe_pc_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 16, PC width.
REQ-002 SHALL have parameter NREG, default 16, architectural register count; RA_W = clog2(NREG).
REQ-003 SHALL have parameter NSTAGE, default 4, pipeline stage count (stage 0 = fetch).
REQ-004 SHALL have parameter ISSUE_STG, default 1, stage that reads operands; BR_STG, default 2, stage that resolves branches; 0 < ISSUE_STG < BR_STG < NSTAGE.
REQ-005 SHALL have parameter SB_W, default 2, per-register scoreboard counter width; RESET_PC, default 0.
REQ-006 SHALL have one clock and an asynchronous active-low reset, ports: CLK in 1 rising-edge clock; RST_N in 1 async active-low reset.
REQ-007 SHALL have: ADV in 1 fetch accepted, advance PC; BR_VALID in 1 branch resolved in BR_STG; BR_PC in PC_W branch instruction address; BR_TARGET in PC_W resolved next address.
REQ-008 SHALL have: ISSUE_VALID in 1; ISSUE_RS, ISSUE_RT in RA_W source registers; ISSUE_USE_RS, ISSUE_USE_RT in 1 source used; ISSUE_WR in 1 writes a register; ISSUE_RD in RA_W destination.
REQ-009 SHALL have: RETIRE_VALID in 1 writeback done; RETIRE_RD in RA_W.
REQ-010 SHALL have: PC_OUT out PC_W fetch address; STAGE_EN out NSTAGE per-stage advance; STAGE_FLUSH out NSTAGE per-stage bubble insert; STALL out 1; FLUSH out 1; STATE out 2.

Function
REQ-011 FLUSH SHALL be combinational: BR_VALID && (BR_TARGET != BR_PC+1 mod 2^PC_W).
REQ-012 Register busy SHALL mean scoreboard counter nonzero; register 0 SHALL never be busy nor counted.
REQ-013 STALL SHALL be combinational: !FLUSH && ISSUE_VALID && ((ISSUE_USE_RS && busy[RS]) || (ISSUE_USE_RT && busy[RT]) || (ISSUE_WR && cnt[RD] == all-ones)).
REQ-014 Flush outputs: STAGE_EN all 1; STAGE_FLUSH bits 0..BR_STG-1 = 1, others 0.
REQ-015 Stall outputs: STAGE_EN bits 0..ISSUE_STG = 0, others 1; STAGE_FLUSH bit ISSUE_STG+1 = 1, others 0.
REQ-016 Otherwise STAGE_EN all 1, STAGE_FLUSH all 0.
REQ-017 PC at rising edge, priority: FLUSH -> BR_TARGET; STALL -> hold; ADV -> PC+1 wrapping to 0 at 2^PC_W; else hold.
REQ-018 Scoreboard: increment cnt[RD] on ISSUE_VALID && ISSUE_WR && !STALL && !FLUSH && RD != 0; decrement cnt[RETIRE_RD] on RETIRE_VALID && RETIRE_RD != 0 && cnt != 0.
REQ-019 Simultaneous increment and decrement of one register SHALL leave it unchanged; decrement at 0 SHALL be ignored.
REQ-020 FLUSH SHALL clear all counters to 0 at the edge, overriding same-cycle issue and retire.
REQ-021 FSM states RUN=0, STALLED=1, REDIR=2, registered, exposed on STATE.
REQ-022 Transitions each edge: FLUSH -> REDIR; else STALL -> STALLED; else RUN; REDIR lasts exactly one cycle unless FLUSH recurs.
REQ-023 In REDIR, ADV SHALL be honoured and ISSUE_VALID SHALL be ignored (no stall, no increment).

Reset
REQ-024 RST_N low SHALL asynchronously set PC_OUT=RESET_PC, all counters 0, STATE=RUN, performance counters 0.
REQ-025 With RST_N low, STALL=0, FLUSH=0, STAGE_EN all 0, STAGE_FLUSH all 1.
REQ-026 Deassertion SHALL take effect at the first rising edge after RST_N high; reset mid-stall SHALL discard all hazard state.

Configuration
REQ-027 With PC_PERF_CNT_EN defined: outputs STALL_CNT, FLUSH_CNT (out 16) count cycles with STALL and with FLUSH, saturating at 0xFFFF.
REQ-028 Without PC_PERF_CNT_EN: those ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset, ADV=1 for 5 cycles -> PC_OUT 0,1,2,3,4,5; STATE=RUN.
REQ-030 Issue write RD=3, next ISSUE RS=3 USE_RS=1 -> STALL=1, STAGE_EN=4'b1100, STAGE_FLUSH=4'b0100, PC holds; RETIRE RD=3 -> STALL drops next cycle.
REQ-031 BR_VALID, BR_PC=0x10, BR_TARGET=0x40 -> FLUSH=1, STAGE_FLUSH=4'b0011, PC_OUT=0x40, counters cleared, STATE=REDIR one cycle.
REQ-032 BR_PC=0x10, BR_TARGET=0x11 -> FLUSH=0; PC=0xFFFF with ADV -> 0x0000.
REQ-033 Three outstanding writes to RD=5 (SB_W=2) -> fourth issue stalls; same-cycle issue+retire RD=5 keeps count 3; write to RD=0 never stalls.

Source files
------------

// File: rtl/pipe_pc_ctrl_if.sv
// Bundle of fetch, branch, issue and retire signals for pipe_pc_ctrl.
// Optional PC_PERF_CNT_EN adds the stall/flush cycle counter outputs.
interface pipe_pc_ctrl_if #(
   parameter int PC_W   = 16,
   parameter int NREG   = 16,
   parameter int NSTAGE = 4
);
   localparam int RA_W = $clog2(NREG);

   logic              ADV;
   logic              BR_VALID;
   logic [PC_W-1:0]   BR_PC;
   logic [PC_W-1:0]   BR_TARGET;
   logic              ISSUE_VALID;
   logic [RA_W-1:0]   ISSUE_RS;
   logic [RA_W-1:0]   ISSUE_RT;
   logic              ISSUE_USE_RS;
   logic              ISSUE_USE_RT;
   logic              ISSUE_WR;
   logic [RA_W-1:0]   ISSUE_RD;
   logic              RETIRE_VALID;
   logic [RA_W-1:0]   RETIRE_RD;
   logic [PC_W-1:0]   PC_OUT;
   logic [NSTAGE-1:0] STAGE_EN;
   logic [NSTAGE-1:0] STAGE_FLUSH;
   logic              STALL;
   logic              FLUSH;
   logic [1:0]        STATE;
`ifdef PC_PERF_CNT_EN
   logic [15:0]       STALL_CNT;
   logic [15:0]       FLUSH_CNT;
`endif

   modport master (
      output ADV, BR_VALID, BR_PC, BR_TARGET,
      output ISSUE_VALID, ISSUE_RS, ISSUE_RT,
      output ISSUE_USE_RS, ISSUE_USE_RT,
      output ISSUE_WR, ISSUE_RD,
      output RETIRE_VALID, RETIRE_RD,
      input  PC_OUT, STAGE_EN, STAGE_FLUSH,
      input  STALL, FLUSH, STATE
`ifdef PC_PERF_CNT_EN
      , input STALL_CNT, FLUSH_CNT
`endif
   );

   modport slave (
      input  ADV, BR_VALID, BR_PC, BR_TARGET,
      input  ISSUE_VALID, ISSUE_RS, ISSUE_RT,
      input  ISSUE_USE_RS, ISSUE_USE_RT,
      input  ISSUE_WR, ISSUE_RD,
      input  RETIRE_VALID, RETIRE_RD,
      output PC_OUT, STAGE_EN, STAGE_FLUSH,
      output STALL, FLUSH, STATE
`ifdef PC_PERF_CNT_EN
      , output STALL_CNT, FLUSH_CNT
`endif
   );
endinterface

// File: rtl/pipe_pc_ctrl.sv
// Fetch PC, register hazard scoreboard and per-stage enable/flush control.
// Optional PC_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_pc_ctrl #(
   parameter int PC_W      = 16,
   parameter int NREG      = 16,
   parameter int NSTAGE    = 4,
   parameter int ISSUE_STG = 1,
   parameter int BR_STG    = 2,
   parameter int SB_W      = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic CLK,
   input logic RST_N,
   pipe_pc_ctrl_if.slave bus
);
   localparam int RA_W = $clog2(NREG);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
   localparam logic [SB_W-1:0] SB_ONE = SB_W'(1);
   localparam logic [SB_W-1:0] SB_MAX = '1;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALLED = 2'd1,
      REDIR   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [SB_W-1:0]   cnt_q [NREG];
   logic [SB_W-1:0]   cnt_d [NREG];
   logic              flush, stall, issue_v;
   logic              busy_rs, busy_rt, full_rd;
   logic              inc, dec;
   logic [NSTAGE-1:0] stage_en, stage_fl;

   always_comb begin
      flush   = RST_N && bus.BR_VALID &&
                (bus.BR_TARGET != bus.BR_PC + PC_ONE);
      // the redirect cycle drops whatever sits in the issue slot
      issue_v = bus.ISSUE_VALID && (state_q != REDIR);
      busy_rs = bus.ISSUE_USE_RS && (cnt_q[bus.ISSUE_RS] != '0);
      busy_rt = bus.ISSUE_USE_RT && (cnt_q[bus.ISSUE_RT] != '0);
      full_rd = bus.ISSUE_WR && (cnt_q[bus.ISSUE_RD] == SB_MAX);
      stall   = RST_N && !flush && issue_v &&
                (busy_rs || busy_rt || full_rd);
      inc     = issue_v && bus.ISSUE_WR && !stall && !flush &&
                (bus.ISSUE_RD != '0);
      dec     = bus.RETIRE_VALID && (bus.RETIRE_RD != '0) &&
                (cnt_q[bus.RETIRE_RD] != '0);
   end

   always_comb begin
      stage_en = '1;
      stage_fl = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         if (!RST_N) begin
            stage_en[i] = 1'b0;
            stage_fl[i] = 1'b1;
         end else if (flush) begin
            stage_fl[i] = (i < BR_STG);
         end else if (stall) begin
            stage_en[i] = (i > ISSUE_STG);
            stage_fl[i] = (i == ISSUE_STG + 1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
         if (flush) begin
            cnt_d[i] = '0;
         end else begin
            if (inc && bus.ISSUE_RD == RA_W'(i) &&
                !(dec && bus.RETIRE_RD == RA_W'(i)))
               cnt_d[i] = cnt_q[i] + SB_ONE;
            else if (dec && bus.RETIRE_RD == RA_W'(i) &&
                     !(inc && bus.ISSUE_RD == RA_W'(i)))
               cnt_d[i] = cnt_q[i] - SB_ONE;
         end
      end
   end

   always_comb begin
      pc_d    = pc_q;
      state_d = RUN;
      if (flush) begin
         pc_d    = bus.BR_TARGET;
         state_d = REDIR;
      end else if (stall) begin
         state_d = STALLED;
      end else if (bus.ADV) begin
         pc_d = pc_q + PC_ONE;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
         for (int i = 0; i < NREG; i++)
            cnt_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         for (int i = 0; i < NREG; i++)
            cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef PC_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush && flush_cnt_q != 16'hFFFF)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.STALL_CNT = stall_cnt_q;
   assign bus.FLUSH_CNT = flush_cnt_q;
`endif

   assign bus.PC_OUT      = pc_q;
   assign bus.STATE       = state_q;
   assign bus.STALL       = stall;
   assign bus.FLUSH       = flush;
   assign bus.STAGE_EN    = stage_en;
   assign bus.STAGE_FLUSH = stage_fl;
endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// Table-driven bench for pipe_pc_ctrl with a queue of expected outputs.
module tb_pipe_pc_ctrl;
   localparam int RUN = 0;
   localparam int STL = 1;
   localparam int RDR = 2;

   typedef struct {
      logic        adv, brv;
      logic [15:0] brpc, brtg;
      logic        iv;
      logic [3:0]  rs, rt;
      logic        urs, urt, wr;
      logic [3:0]  rd;
      logic        rv;
      logic [3:0]  rrd;
      logic [15:0] pc;
      logic        stall, flush;
      logic [3:0]  en, fl;
      logic [1:0]  st;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_pc_ctrl_if #(.PC_W(16), .NREG(16), .NSTAGE(4)) bus ();

   pipe_pc_ctrl #(
      .PC_W(16), .NREG(16), .NSTAGE(4), .ISSUE_STG(1),
      .BR_STG(2), .SB_W(2), .RESET_PC(16'h0000)
   ) dut (
      .CLK(clk),
      .RST_N(rst_n),
      .bus(bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t exp_q[$];
   vec_t tv[$];

   function automatic vec_t mk(
      int adv, int brv, int brpc, int brtg, int iv, int rs, int rt,
      int urs, int urt, int wr, int rd, int rv, int rrd,
      int pc, int stl, int fls, int st);
      vec_t v;
      v.adv = 1'(adv); v.brv = 1'(brv);
      v.brpc = 16'(brpc); v.brtg = 16'(brtg);
      v.iv = 1'(iv); v.rs = 4'(rs); v.rt = 4'(rt);
      v.urs = 1'(urs); v.urt = 1'(urt); v.wr = 1'(wr);
      v.rd = 4'(rd); v.rv = 1'(rv); v.rrd = 4'(rrd);
      v.pc = 16'(pc); v.stall = 1'(stl); v.flush = 1'(fls);
      v.st = 2'(st);
      v.en = fls ? 4'b1111 : (stl ? 4'b1100 : 4'b1111);
      v.fl = fls ? 4'b0011 : (stl ? 4'b0100 : 4'b0000);
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic drive(vec_t v);
      bus.ADV          = v.adv;
      bus.BR_VALID     = v.brv;
      bus.BR_PC        = v.brpc;
      bus.BR_TARGET    = v.brtg;
      bus.ISSUE_VALID  = v.iv;
      bus.ISSUE_RS     = v.rs;
      bus.ISSUE_RT     = v.rt;
      bus.ISSUE_USE_RS = v.urs;
      bus.ISSUE_USE_RT = v.urt;
      bus.ISSUE_WR     = v.wr;
      bus.ISSUE_RD     = v.rd;
      bus.RETIRE_VALID = v.rv;
      bus.RETIRE_RD    = v.rrd;
   endtask

   task automatic check_out(int idx);
      vec_t e;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      chk($sformatf("pc[%0d]", idx), 32'(bus.PC_OUT), 32'(e.pc));
      chk($sformatf("stall[%0d]", idx), 32'(bus.STALL), 32'(e.stall));
      chk($sformatf("flush[%0d]", idx), 32'(bus.FLUSH), 32'(e.flush));
      chk($sformatf("en[%0d]", idx), 32'(bus.STAGE_EN), 32'(e.en));
      chk($sformatf("sfl[%0d]", idx), 32'(bus.STAGE_FLUSH), 32'(e.fl));
      chk($sformatf("state[%0d]", idx), 32'(bus.STATE), 32'(e.st));
   endtask

   task automatic apply(vec_t v, int idx);
      @(posedge clk);
      #1;
      drive(v);
      exp_q.push_back(v);
      @(negedge clk);
      check_out(idx);
   endtask

   initial begin
      // power-on / count-up
      for (int i = 0; i < 5; i++)
         tv.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0, 0,0, i,0,0,RUN));
      tv.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 0,0, 5,0,0,RUN));
      // RAW hazard on r3, released by retire
      tv.push_back(mk(1,0,0,0, 1,0,0,0,0,1,3, 0,0, 5,0,0,RUN));
      tv.push_back(mk(1,0,0,0, 1,3,0,1,0,0,0, 0,0, 6,1,0,RUN));
      tv.push_back(mk(1,0,0,0, 1,3,0,1,0,0,0, 1,3, 6,1,0,STL));
      tv.push_back(mk(1,0,0,0, 1,3,0,1,0,1,4, 0,0, 6,0,0,STL));
      // taken branch clears r4, redirect ignores issue of r6
      tv.push_back(mk(1,1,'h10,'h40, 1,0,0,0,0,1,7, 0,0, 7,0,1,RUN));
      tv.push_back(mk(1,0,0,0, 1,0,0,0,0,1,6, 0,0, 'h40,0,0,RDR));
      tv.push_back(mk(1,0,0,0, 1,4,6,1,1,0,0, 0,0, 'h41,0,0,RUN));
      tv.push_back(mk(1,1,'h10,'h11, 0,0,0,0,0,0,0, 0,0, 'h42,0,0,RUN));
      // r5 counter saturation
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,5, 0,0, 'h43,0,0,RUN));
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,5, 0,0, 'h43,0,0,RUN));
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,5, 1,5, 'h43,0,0,RUN));
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,5, 0,0, 'h43,0,0,RUN));
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,5, 0,0, 'h43,1,0,RUN));
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,0, 1,5, 'h43,0,0,STL));
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,0, 0,0, 'h43,0,0,RUN));
      tv.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 1,9, 'h43,0,0,RUN));
      tv.push_back(mk(0,0,0,0, 1,9,0,1,0,0,0, 0,0, 'h43,0,0,RUN));
      tv.push_back(mk(0,0,0,0, 1,0,5,0,1,0,0, 0,0, 'h43,1,0,RUN));
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,5, 0,0, 'h43,0,0,STL));
      tv.push_back(mk(1,0,0,0, 1,0,0,0,0,1,5, 0,0, 'h43,1,0,RUN));
      tv.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0, 0,0, 'h43,0,0,STL));
      // PC wrap via branch to 0xFFFF
      tv.push_back(mk(0,1,0,'hFFFF, 0,0,0,0,0,0,0, 0,0, 'h44,0,1,RUN));
      tv.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0, 0,0, 'hFFFF,0,0,RDR));
      tv.push_back(mk(0,0,0,0, 1,0,0,0,0,1,2, 0,0, 0,0,0,RUN));
      // flush beats a pending stall
      tv.push_back(mk(0,1,0,'h20, 1,2,0,1,0,0,0, 0,0, 0,0,1,RUN));
      tv.push_back(mk(0,0,0,0, 1,2,0,1,0,0,0, 0,0, 'h20,0,0,RDR));
      tv.push_back(mk(0,0,0,0, 1,2,0,1,0,0,0, 0,0, 'h20,0,0,RUN));
      tv.push_back(mk(0,1,'hFFFF,0, 0,0,0,0,0,0,0, 0,0, 'h20,0,0,RUN));

      // reset with a taken branch and hazardous issue on the inputs
      drive(mk(0,1,'h10,'h40, 1,0,0,1,0,1,3, 0,0, 0,0,0,RUN));
      repeat (2) @(negedge clk);
      chk("rst_flush", 32'(bus.FLUSH), 32'd0);
      chk("rst_stall", 32'(bus.STALL), 32'd0);
      chk("rst_en", 32'(bus.STAGE_EN), 32'h0);
      chk("rst_sfl", 32'(bus.STAGE_FLUSH), 32'hF);
      chk("rst_pc", 32'(bus.PC_OUT), 32'h0);
      chk("rst_state", 32'(bus.STATE), 32'(RUN));
      drive(mk(0,0,0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,RUN));
      rst_n = 1'b1;

      for (int i = 0; i < tv.size(); i++)
         apply(tv[i], i);

      // async reset while stalled drops the hazard
      apply(mk(0,0,0,0, 1,0,0,0,0,1,3, 0,0, 'h20,0,0,RUN), 100);
      apply(mk(0,0,0,0, 1,3,0,1,0,0,0, 0,0, 'h20,1,0,RUN), 101);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_pc", 32'(bus.PC_OUT), 32'h0);
      chk("mid_rst_stall", 32'(bus.STALL), 32'd0);
      chk("mid_rst_en", 32'(bus.STAGE_EN), 32'h0);
      chk("mid_rst_sfl", 32'(bus.STAGE_FLUSH), 32'hF);
      #1 rst_n = 1'b1;
      apply(mk(0,0,0,0, 1,3,0,1,0,0,0, 0,0, 0,0,0,RUN), 102);
      apply(mk(1,0,0,0, 0,0,0,0,0,0,0, 0,0, 0,0,0,RUN), 103);
      apply(mk(0,0,0,0, 0,0,0,0,0,0,0, 0,0, 1,0,0,RUN), 104);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
